mine_adjacency: RTL and testbench
=================================

// Module: mine_adjacency
// PURPOSE
//  Consumes the 25-bit mine map produced by the mine generator and builds the
//  displayed board: one count per cell giving the number of adjacent mines.
//  Mine cells get a marker code instead of a count. A FSM scans one cell per
//  clock. The packed result feeds the board/display logic.
// PARAMETERS
//  ROWS       5   board rows; cell index = row*COLS+col, cell 0 = top-left
//  COLS       5   board columns; N = ROWS*COLS
//  CW         4   bits per cell count field
//  MINE_CODE  9   value written to CW-bit field of a cell that holds a mine
// PORTS
//  in_clka         in   1     clock, all state on posedge
//  in_reset        in   1     synchronous reset, active-high
//  in_start        in   1     request a scan; honoured only in IDLE
//  in_mines        in   N     mine map, bit i = 1 -> mine in cell i
//  out_counts      out  N*CW  cell i count at [i*CW +: CW]
//  out_mine_total  out  5     number of mines in the latched map
//  out_busy        out  1     high from start acceptance until return to IDLE
//  out_done        out  1     one-cycle pulse, results valid
// BEHAVIOUR
//  - One clock (in_clka). Reset is synchronous and active-high (in_reset).
//    Reset wins over every other input, including in_start in the same cycle.
//  - Reset values: all outputs 0, state IDLE, internal map/index/row/col 0.
//  - States: IDLE -> SCAN -> DONE -> IDLE.
//  - IDLE: on in_start=1 at edge k: latch in_mines, clear out_counts and
//    out_mine_total, idx=row=col=0, out_busy<=1, go SCAN.
//  - SCAN: edges k+1..k+N each write one cell, idx ascending. Field value is
//    MINE_CODE if the cell is a mine. Otherwise it is the sum of the up-to-8
//    neighbours (row+-1, col+-1) that lie on the board. out_mine_total += bit.
//  - Row/col are kept as counters: col wraps COLS-1 -> 0 and increments row.
//    No divide/modulo on idx.
//  - Edges: off-board neighbours are skipped. No wrap-around between rows or
//    columns, e.g. cell 4 and cell 5 are not neighbours. Corner cells have 3
//    neighbours, edge cells 5, interior cells 8.
//  - At edge k+N (last cell written): state<=DONE, out_done<=1.
//  - DONE: at edge k+N+1: out_done<=0, out_busy<=0, go IDLE.
//    Latency: start sampled -> out_done high = N cycles (25 by default).
//  - out_counts and out_mine_total hold their values until the next accepted
//    start or reset.
//  - in_start in SCAN or DONE is ignored, not queued. in_mines changes after
//    acceptance do not affect the scan in progress.
//  - Reset mid-scan aborts the scan: outputs zeroed, IDLE. The next start is
//    accepted normally.
//  - Max neighbour sum 8 < MINE_CODE; CW must hold MINE_CODE. Widths are
//    unsigned, with no overflow for defaults.
// TESTING
//  1 Reset: hold in_reset 2 cycles mid-activity -> out_counts=0,
//    out_mine_total=0, out_busy=0, out_done=0.
//  2 Centre mine: in_mines=25'h0001000 (cell 12) -> cells 6,7,8,11,13,16,17,18
//    =1, cell 12 =9, rest 0, total=1. out_done high exactly 25 cycles after the
//    start edge, for 1 cycle.
//  3 No wrap: in_mines=25'h0000010 (cell 4) -> cells 3,8,9 =1, cell 4 =9,
//    cell 5 =0. in_mines=25'h0000001 -> cells 1,5,6 =1.
//  4 Dense: in_mines=25'h1FFEFFF -> cell 12 =8, all other cells 9, total=24.
//    in_mines=25'h1FFFFFF -> all 9, total=25.
//  5 Abort/ignore: start, pulse in_start again at scan cycle 5 -> no effect.
//    in_reset at scan cycle 10 -> all outputs 0. New start with 25'h0001000
//    -> matches scenario 2.
//  6 Back-to-back: in_start held high through DONE -> accepted only on the
//    first IDLE cycle after DONE. Second map's results replace the first.

Source files
------------

// File: rtl/mine_adjacency.sv
// mine_adjacency: latches a mine map and walks the board one cell per clock.
// Each cell gets either MINE_CODE or its count of on-board neighbouring mines.
// The packed counts and the mine total are held until the next accepted start.
module mine_adjacency #(
  parameter int ROWS      = 5,
  parameter int COLS      = 5,
  parameter int CW        = 4,
  parameter int MINE_CODE = 9
) (
  input  logic                      in_clka,
  input  logic                      in_reset,
  input  logic                      in_start,
  input  logic [ROWS*COLS-1:0]      in_mines,
  output logic [ROWS*COLS*CW-1:0]   out_counts,
  output logic [4:0]                out_mine_total,
  output logic                      out_busy,
  output logic                      out_done
);

  localparam int N   = ROWS * COLS;
  localparam int IW  = (N > 1) ? $clog2(N) : 1;
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [N-1:0]        r_map;
  logic [IW-1:0]       r_idx;
  logic [RW-1:0]       r_row;
  logic [CLW-1:0]      r_col;
  logic [N*CW-1:0]     r_counts;
  logic [4:0]          r_total;
  logic                r_busy;
  logic                r_done;

  logic                w_last;
  logic [CW-1:0]       w_sum;
  logic [CW-1:0]       w_cell;
  logic [IW-1:0]       w_nidx;
  logic                w_row_ok;
  logic                w_col_ok;

  assign w_last = (r_idx == IW'(N - 1));

  // State register.
  always_ff @(posedge in_clka) begin
    if (in_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: IDLE -> SCAN -> DONE -> IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (in_start) w_next = ST_SCAN;
      ST_SCAN: if (w_last)   w_next = ST_DONE;
      ST_DONE:               w_next = ST_IDLE;
      default:               w_next = ST_IDLE;
    endcase
  end

  // Neighbour sum of the current cell. Row/col counters only gate the board
  // edges; the neighbour index is idx offset by (dr-1)*COLS + (dc-1), which is
  // in range whenever both edge gates pass, so no divide/modulo is needed.
  always_comb begin
    w_sum    = '0;
    w_nidx   = '0;
    w_row_ok = 1'b0;
    w_col_ok = 1'b0;
    for (int unsigned dr = 0; dr < 3; dr++) begin
      for (int unsigned dc = 0; dc < 3; dc++) begin
        w_row_ok = !((dr == 0 && r_row == '0) ||
                     (dr == 2 && r_row == RW'(ROWS - 1)));
        w_col_ok = !((dc == 0 && r_col == '0) ||
                     (dc == 2 && r_col == CLW'(COLS - 1)));
        if (!(dr == 1 && dc == 1) && w_row_ok && w_col_ok) begin
          w_nidx = IW'(32'(r_idx) + dr * COLS + dc - COLS - 1);
          w_sum  = w_sum + CW'(r_map[w_nidx]);
        end
      end
    end
    w_cell = r_map[r_idx] ? CW'(MINE_CODE) : w_sum;
  end

  // Datapath: latch on accepted start, write one cell per SCAN cycle.
  always_ff @(posedge in_clka) begin
    if (in_reset) begin
      r_map    <= '0;
      r_idx    <= '0;
      r_row    <= '0;
      r_col    <= '0;
      r_counts <= '0;
      r_total  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_start) begin
            r_map    <= in_mines;
            r_counts <= '0;
            r_total  <= '0;
            r_idx    <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_busy   <= 1'b1;
          end
        end
        ST_SCAN: begin
          for (int unsigned i = 0; i < N; i++) begin
            if (r_idx == IW'(i)) r_counts[i*CW +: CW] <= w_cell;
          end
          r_total <= r_total + 5'(r_map[r_idx]);
          if (w_last) begin
            r_done <= 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
            if (r_col == CLW'(COLS - 1)) begin
              r_col <= '0;
              r_row <= r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_done <= 1'b0;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign out_counts     = r_counts;
  assign out_mine_total = r_total;
  assign out_busy       = r_busy;
  assign out_done       = r_done;

endmodule

// File: tb/tb_mine_adjacency.sv
// Testbench for mine_adjacency: fixed vector table, random maps against a
// grid-based reference model, and hand-written abort/ignore/back-to-back runs.
module tb_mine_adjacency;

  localparam int ROWS = 5;
  localparam int COLS = 5;
  localparam int CW   = 4;
  localparam int N    = ROWS * COLS;
  localparam int W    = N * CW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [N-1:0]  mines;
  logic [W-1:0]  counts;
  logic [4:0]    total;
  logic          busy;
  logic          done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mine_adjacency #(
    .ROWS(ROWS),
    .COLS(COLS),
    .CW(CW),
    .MINE_CODE(9)
  ) dut (
    .in_clka(clk),
    .in_reset(rst),
    .in_start(start),
    .in_mines(mines),
    .out_counts(counts),
    .out_mine_total(total),
    .out_busy(busy),
    .out_done(done)
  );

  typedef struct {
    string        name;
    logic [N-1:0] m;
    logic [W-1:0] exp_counts;
    logic [4:0]   exp_total;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: walk a 2-D board, counting mines in the 3x3 window clipped to the board.
  function automatic logic [W-1:0] model_counts(input logic [N-1:0] m);
    logic [W-1:0] res;
    logic [N-1:0] sh;
    logic [W-1:0] fld;
    int cnt;
    res = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        sh = m >> (r * COLS + c);
        if (sh[0]) begin
          cnt = 9;
        end else begin
          cnt = 0;
          for (int rr = r - 1; rr <= r + 1; rr++)
            for (int cc = c - 1; cc <= c + 1; cc++)
              if (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS && !(rr == r && cc == c)) begin
                sh = m >> (rr * COLS + cc);
                cnt += int'(sh[0]);
              end
        end
        fld = W'(cnt);
        res = res | (fld << ((r * COLS + c) * CW));
      end
    end
    return res;
  endfunction

  // Present a map and raise start for the acceptance edge; optionally keep start high.
  task automatic start_scan(input logic [N-1:0] m, input bit hold);
    @(negedge clk);
    mines = m;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    mines = N'($urandom);
  endtask

  // Count cycles from acceptance edge to done; optional one-cycle start pulse.
  task automatic wait_done(input int pulse_at, output int lat);
    lat = 0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      #1;
      lat = c;
      if (pulse_at > 0) start = (c == pulse_at);
      if (done) break;
    end
    if (pulse_at > 0) start = 1'b0;
  endtask

  task automatic run_vec(input string name, input logic [N-1:0] m,
                         input logic [W-1:0] ec, input logic [4:0] et);
    int lat;
    start_scan(m, 1'b0);
    chk({name, "_busy_on"}, W'(busy), W'(1));
    chk({name, "_clear"}, counts, '0);
    wait_done(-1, lat);
    chk({name, "_latency"}, W'(lat), W'(25));
    chk({name, "_counts"}, counts, ec);
    chk({name, "_total"}, W'(total), W'(et));
    @(posedge clk);
    #1;
    chk({name, "_done_pulse"}, W'(done), W'(0));
    chk({name, "_busy_off"}, W'(busy), W'(0));
    repeat (2) @(posedge clk);
    #1;
    chk({name, "_hold"}, counts, ec);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] ma, mb;
    int lat;

    tbl[0] = '{"centre",  25'h0001000, 100'h0000001110019100111000000, 5'd1};
    tbl[1] = '{"corner4", 25'h0000010, 100'h0000000000000001100091000, 5'd1};
    tbl[2] = '{"corner0", 25'h0000001, 100'h0000000000000000001100019, 5'd1};
    tbl[3] = '{"dense24", 25'h1FFEFFF, 100'h9999999999998999999999999, 5'd24};
    tbl[4] = '{"full",    25'h1FFFFFF, 100'h9999999999999999999999999, 5'd25};
    tbl[5] = '{"empty",   25'h0000000, 100'h0000000000000000000000000, 5'd0};

    rst   = 1'b1;
    start = 1'b0;
    mines = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_counts", counts, '0);
    chk("reset_total", W'(total), W'(0));
    chk("reset_busy", W'(busy), W'(0));
    chk("reset_done", W'(done), W'(0));
    rst = 1'b0;

    for (int i = 0; i < 6; i++)
      run_vec(tbl[i].name, tbl[i].m, tbl[i].exp_counts, tbl[i].exp_total);

    for (int i = 0; i < 16; i++) begin
      ma = N'($urandom);
      if (i % 4 == 1) ma = ma & N'($urandom);
      if (i % 4 == 2) ma = ma | N'($urandom);
      run_vec("random", ma, model_counts(ma), 5'($countones(ma)));
    end

    // Start pulse mid-scan must be ignored.
    start_scan(25'h0001000, 1'b0);
    wait_done(5, lat);
    chk("ignore_latency", W'(lat), W'(25));
    chk("ignore_counts", counts, tbl[0].exp_counts);
    repeat (3) @(posedge clk);
    #1;
    chk("ignore_no_queue", W'(busy), W'(0));

    // Reset mid-scan with start asserted: reset wins, everything cleared.
    start_scan(25'h1FFFFFF, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    rst   = 1'b1;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_counts", counts, '0);
    chk("abort_total", W'(total), W'(0));
    chk("abort_busy", W'(busy), W'(0));
    chk("abort_done", W'(done), W'(0));
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_idle", W'(busy), W'(0));
    run_vec("after_abort", tbl[0].m, tbl[0].exp_counts, tbl[0].exp_total);

    // Start held high through DONE: second map accepted on first IDLE cycle.
    ma = N'($urandom);
    mb = ~ma;
    start_scan(ma, 1'b1);
    mines = mb;
    wait_done(-1, lat);
    chk("b2b_first_latency", W'(lat), W'(25));
    chk("b2b_first_counts", counts, model_counts(ma));
    @(posedge clk);
    #1;
    chk("b2b_idle_busy", W'(busy), W'(0));
    @(posedge clk);
    #1;
    chk("b2b_accept_busy", W'(busy), W'(1));
    chk("b2b_accept_clear", counts, '0);
    start = 1'b0;
    wait_done(-1, lat);
    chk("b2b_second_latency", W'(lat), W'(25));
    chk("b2b_second_counts", counts, model_counts(mb));
    chk("b2b_second_total", W'(total), W'($countones(mb)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
